qm_writeback: RTL and testbench

//  Final (WB) stage of the q3kmips pipeline: produces the register-file write port (WA/WE/WD)

---
 rtl/qm_writeback_pkg.sv | 23 ++
 rtl/qm_writeback.sv | 107 ++++++++++
 tb/tb_qm_writeback.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/qm_writeback_pkg.sv
// Shared types and constants for the q3kmips writeback stage.
package qm_writeback_pkg;

  typedef enum logic {
    QM_WB_IDLE = 1'b0,
    QM_WB_WAIT = 1'b1
  } qm_wb_state_e;

  localparam logic       QM_WSRC_MEM = 1'b1;
  localparam logic [4:0] QM_REG_ZERO = 5'd0;

  // A load is an instruction that writes the register file from memory data.
  // A store also selects the memory source but never writes, so it is not a load.
  function automatic logic is_load(input logic reg_write, input logic wsrc);
    return reg_write && (wsrc == QM_WSRC_MEM);
  endfunction

  // Register $zero is hardwired; a write to it must never be strobed.
  function automatic logic wb_allowed(input logic [4:0] wa);
    return wa != QM_REG_ZERO;
  endfunction

endpackage

// File: rtl/qm_writeback.sv
// Writeback stage: registered MEM/WB boundary, load wait with timeout, and the
// register-file write port driven back to decode.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// QM_WB_IDLE | accepting MEM-stage instructions, no load outstanding
// QM_WB_WAIT | load outstanding; stalling upstream until data or timeout
module qm_writeback
  import qm_writeback_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        di_Valid,
  input  logic [31:0] di_ALUResult,
  input  logic [4:0]  di_WriteReg,
  input  logic        ci_RegWrite,
  input  logic        ci_RegWSource,
  input  logic [31:0] di_MemRData,
  input  logic        di_MemRValid,
  output logic [4:0]  do_WA,
  output logic        do_WE,
  output logic [31:0] do_WD,
  output logic        co_Stall,
  output logic        co_LoadTimeout
);

  qm_wb_state_e  state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [4:0]    lreg_q, lreg_d;
  logic [4:0]    wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;
  logic          we_q, we_d;
  logic          to_q, to_d;

  // Next-state logic: accept in IDLE, wait for the load response or give up.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lreg_d  = lreg_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      QM_WB_IDLE: begin
        if (di_Valid) begin
          if (is_load(ci_RegWrite, ci_RegWSource)) begin
            lreg_d  = di_WriteReg;
            cnt_d   = '0;
            state_d = QM_WB_WAIT;
          end else if (ci_RegWrite) begin
            // Stores and non-writing ops leave WA/WD holding the last write.
            wa_d = di_WriteReg;
            wd_d = di_ALUResult;
            we_d = wb_allowed(di_WriteReg);
          end
        end
      end
      QM_WB_WAIT: begin
        // Data arriving on the final timeout cycle still completes the load.
        if (di_MemRValid) begin
          wa_d    = lreg_q;
          wd_d    = di_MemRData;
          we_d    = wb_allowed(lreg_q);
          state_d = QM_WB_IDLE;
        end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          to_d    = 1'b1;
          state_d = QM_WB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = QM_WB_IDLE;
    endcase
  end

  // State, MEM/WB registers and timeout counter, with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= QM_WB_IDLE;
      cnt_q   <= '0;
      lreg_q  <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lreg_q  <= lreg_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      to_q    <= to_d;
    end
  end

  assign co_Stall       = (state_q == QM_WB_WAIT);
  assign do_WA          = wa_q;
  assign do_WE          = we_q;
  assign do_WD          = wd_q;
  assign co_LoadTimeout = to_q;

endmodule

// File: tb/tb_qm_writeback.sv
// Self-checking bench for qm_writeback using a transaction-level reference model.
module tb_qm_writeback;

  localparam int T = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        di_Valid;
  logic [31:0] di_ALUResult;
  logic [4:0]  di_WriteReg;
  logic        ci_RegWrite;
  logic        ci_RegWSource;
  logic [31:0] di_MemRData;
  logic        di_MemRValid;
  logic [4:0]  do_WA;
  logic        do_WE;
  logic [31:0] do_WD;
  logic        co_Stall;
  logic        co_LoadTimeout;

  int checks = 0;
  int errors = 0;

  // Model of the write port's held address/data.
  logic [4:0]  exp_wa;
  logic [31:0] exp_wd;

  qm_writeback #(.TIMEOUT_CYCLES(T), .TW(3)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .di_Valid(di_Valid),
    .di_ALUResult(di_ALUResult), .di_WriteReg(di_WriteReg),
    .ci_RegWrite(ci_RegWrite), .ci_RegWSource(ci_RegWSource),
    .di_MemRData(di_MemRData), .di_MemRValid(di_MemRValid),
    .do_WA(do_WA), .do_WE(do_WE), .do_WD(do_WD),
    .co_Stall(co_Stall), .co_LoadTimeout(co_LoadTimeout)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [39:0] obs();
    return {co_Stall, co_LoadTimeout, do_WE, do_WA, do_WD};
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Present one non-load instruction for a single edge.
  task automatic send_alu(input logic rw, input logic ws, input logic [4:0] r, input logic [31:0] d);
    di_Valid = 1'b1; ci_RegWrite = rw; ci_RegWSource = ws; di_WriteReg = r; di_ALUResult = d;
    step();
    di_Valid = 1'b0;
  endtask

  // Expected port state after a non-load instruction (model update included).
  function automatic logic [39:0] model_alu(input logic rw, input logic [4:0] r, input logic [31:0] d);
    if (rw) begin
      exp_wa = r;
      exp_wd = d;
    end
    return {1'b0, 1'b0, rw && (r != 5'd0), exp_wa, exp_wd};
  endfunction

  // One load; response arrives in WAIT cycle d (d=0 means never).
  task automatic run_load(input logic [4:0] r, input int d, input logic [31:0] data,
                          input bit keep_valid, input string tag);
    logic [39:0] exp;
    bit responded;
    int n;
    di_Valid = 1'b1; ci_RegWrite = 1'b1; ci_RegWSource = 1'b1;
    di_WriteReg = r; di_ALUResult = $urandom;
    step();
    if (!keep_valid) di_Valid = 1'b0;
    responded = (d >= 1) && (d <= T);
    n = responded ? d : T;
    for (int i = 1; i <= n; i++) begin
      exp = {1'b1, 1'b0, 1'b0, exp_wa, exp_wd};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL %s wait%0d: got %h want %h", tag, i, obs(), exp);
      end
      if (responded && i == d) begin
        di_MemRValid = 1'b1; di_MemRData = data;
      end else begin
        di_MemRValid = 1'b0; di_MemRData = $urandom;
      end
      step();
    end
    di_MemRValid = 1'b0;
    di_Valid = 1'b0;
    if (responded) begin
      exp_wa = r;
      exp_wd = data;
      exp = {1'b0, 1'b0, r != 5'd0, exp_wa, exp_wd};
    end else begin
      exp = {1'b0, 1'b1, 1'b0, exp_wa, exp_wd};
    end
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL %s done: got %h want %h", tag, obs(), exp);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; di_Valid = 1'b0; di_ALUResult = '0; di_WriteReg = '0;
    ci_RegWrite = 1'b0; ci_RegWSource = 1'b0; di_MemRData = '0; di_MemRValid = 1'b0;
    step(); step();
    exp_wa = '0; exp_wd = '0;
    checks++;
    if (obs() !== 40'd0) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs(), 40'd0);
    end
    sys_rst = 1'b0;
    step();
  endtask

  task automatic test_alu();
    logic [39:0] exp;
    send_alu(1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
    exp = model_alu(1'b1, 5'd5, 32'hDEADBEEF);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL alu: got %h want %h", obs(), exp);
    end
    step();
    exp = {1'b0, 1'b0, 1'b0, exp_wa, exp_wd};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL alu_hold: got %h want %h", obs(), exp);
    end
    send_alu(1'b0, 1'b1, 5'd7, 32'h0BAD0BAD);
    exp = model_alu(1'b0, 5'd7, 32'h0BAD0BAD);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL store: got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_load();
    run_load(5'd9, 3, 32'h12345678, 1'b0, "load_d3");
    run_load(5'd10, 1, 32'hA5A5A5A5, 1'b1, "load_d1");
    run_load(5'd11, T, 32'h5A5A0001, 1'b0, "load_dT");
  endtask

  task automatic test_zero();
    logic [39:0] exp;
    send_alu(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF);
    exp = model_alu(1'b1, 5'd0, 32'hFFFFFFFF);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL zero_alu: got %h want %h", obs(), exp);
    end
    run_load(5'd0, 2, 32'hCAFEF00D, 1'b0, "zero_load");
  endtask

  task automatic test_timeout();
    logic [39:0] exp;
    run_load(5'd12, 0, 32'h0, 1'b1, "timeout_never");
    di_MemRValid = 1'b1; di_MemRData = 32'h77777777;
    step();
    di_MemRValid = 1'b0;
    exp = {1'b0, 1'b0, 1'b0, exp_wa, exp_wd};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL stray: got %h want %h", obs(), exp);
    end
    run_load(5'd13, T + 1, 32'h0, 1'b0, "timeout_late");
    send_alu(1'b1, 1'b0, 5'd14, 32'h00C0FFEE);
    exp = model_alu(1'b1, 5'd14, 32'h00C0FFEE);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL after_timeout: got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] exp;
    for (int i = 1; i <= 3; i++) begin
      send_alu(1'b1, 1'b0, 5'(i), 32'h100 + 32'(i));
      exp = model_alu(1'b1, 5'(i), 32'h100 + 32'(i));
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL b2b%0d: got %h want %h", i, obs(), exp);
      end
    end
    run_load(5'd20, 2, 32'h20202020, 1'b0, "b2b_load");
    send_alu(1'b1, 1'b0, 5'd21, 32'h21212121);
    exp = model_alu(1'b1, 5'd21, 32'h21212121);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL b2b_after_load: got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_random();
    logic [39:0] exp;
    logic rw, ws;
    logic [4:0] r;
    logic [31:0] d;
    for (int k = 0; k < 60; k++) begin
      rw = 1'($urandom); ws = 1'($urandom);
      r = 5'($urandom_range(0, 31)); d = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        di_MemRValid = 1'($urandom); di_MemRData = $urandom;
        step();
        di_MemRValid = 1'b0;
        exp = {1'b0, 1'b0, 1'b0, exp_wa, exp_wd};
        checks++;
        if (obs() !== exp) begin
          errors++;
          $display("FAIL rand_idle%0d: got %h want %h", k, obs(), exp);
        end
      end else if (rw && ws) begin
        run_load(r, $urandom_range(0, T + 1), d, 1'($urandom), "rand_load");
      end else begin
        send_alu(rw, ws, r, d);
        exp = model_alu(rw, r, d);
        checks++;
        if (obs() !== exp) begin
          errors++;
          $display("FAIL rand_alu%0d: got %h want %h", k, obs(), exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    di_Valid = 1'b1; ci_RegWrite = 1'b1; ci_RegWSource = 1'b1;
    di_WriteReg = 5'd17; di_ALUResult = 32'h0;
    step();
    di_Valid = 1'b0;
    step();
    sys_rst = 1'b1; di_MemRValid = 1'b1; di_MemRData = 32'h99999999;
    step();
    exp_wa = '0; exp_wd = '0;
    checks++;
    if (obs() !== 40'd0) begin
      errors++;
      $display("FAIL rst_mid_load: got %h want %h", obs(), 40'd0);
    end
    sys_rst = 1'b0;
    step();
    di_MemRValid = 1'b0;
    checks++;
    if (obs() !== 40'd0) begin
      errors++;
      $display("FAIL rst_then_resp: got %h want %h", obs(), 40'd0);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_zero();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
